// File: rtl/mem_arb_if.sv
// ---------------------------------------------------------------------------
// mem_arb_if
// Bundles the signals between the two requesters, the arbiter and the shared
// 16-bit memory port.
//
//   Requester side (per requester N = 0,1):
//     rN_req        level request, held until rN_ack
//     rN_addr       word address
//     rN_dati       write data
//     rN_we_hi/lo   byte-lane write enables (both low = read)
//     rN_ack        one-cycle completion pulse
//     rN_dato       read data, valid from ack until that requester's next ack
//   Memory side:
//     mem_addr, mem_dati, mem_oe, mem_we_hi, mem_we_lo   registered strobes
//     mem_dato      read data returned by the memory
//   Status:
//     busy          high whenever the arbiter is not idle
//
// Modports:
//   slave  - the arbiter (consumes requests, drives the memory port)
//   master - the environment (requesters plus memory model)
// ---------------------------------------------------------------------------
interface mem_arb_if #(
  parameter int AW = 24
);
  logic          r0_req;
  logic          r1_req;
  logic [AW-1:0] r0_addr;
  logic [AW-1:0] r1_addr;
  logic [15:0]   r0_dati;
  logic [15:0]   r1_dati;
  logic          r0_we_hi;
  logic          r0_we_lo;
  logic          r1_we_hi;
  logic          r1_we_lo;
  logic          r0_ack;
  logic          r1_ack;
  logic [15:0]   r0_dato;
  logic [15:0]   r1_dato;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_dati;
  logic          mem_oe;
  logic          mem_we_hi;
  logic          mem_we_lo;
  logic [15:0]   mem_dato;
  logic          busy;

  modport slave (
    input  r0_req, r1_req, r0_addr, r1_addr, r0_dati, r1_dati,
           r0_we_hi, r0_we_lo, r1_we_hi, r1_we_lo, mem_dato,
    output r0_ack, r1_ack, r0_dato, r1_dato,
           mem_addr, mem_dati, mem_oe, mem_we_hi, mem_we_lo, busy
  );

  modport master (
    output r0_req, r1_req, r0_addr, r1_addr, r0_dati, r1_dati,
           r0_we_hi, r0_we_lo, r1_we_hi, r1_we_lo, mem_dato,
    input  r0_ack, r1_ack, r0_dato, r1_dato,
           mem_addr, mem_dati, mem_oe, mem_we_hi, mem_we_lo, busy
  );
endinterface

// File: rtl/mem_arb.sv
// ---------------------------------------------------------------------------
// mem_arb
// Round-robin arbiter and access sequencer for one shared 16-bit memory port.
// Requester 0 is the CPU memory IO engine, requester 1 the MCU/PI bulk path.
// A granted access holds the registered memory strobes for WAIT_CYC cycles,
// captures read data on the last strobe cycle and returns a one-cycle ack to
// the winner. One access occupies WAIT_CYC+2 cycles (IDLE, ACCESS x WAIT_CYC,
// DONE). All outputs come straight from flops.
//
// Parameters:
//   AW        address width
//   WAIT_CYC  cycles the memory strobe is held, 1..15
// Ports:
//   clk       system clock
//   sys_rst   asynchronous reset, active high
//   bus       mem_arb_if slave modport (requesters + memory port + busy)
// ---------------------------------------------------------------------------
module mem_arb #(
  parameter int AW       = 24,
  parameter int WAIT_CYC = 4
) (
  input logic      clk,
  input logic      sys_rst,
  mem_arb_if.slave bus
);

  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [15:0]      mem_dati_q, mem_dati_d;
  logic             mem_oe_q, mem_oe_d;
  logic             mem_we_hi_q, mem_we_hi_d;
  logic             mem_we_lo_q, mem_we_lo_d;
  logic             r0_ack_q, r0_ack_d;
  logic             r1_ack_q, r1_ack_d;
  logic [15:0]      r0_dato_q, r0_dato_d;
  logic [15:0]      r1_dato_q, r1_dato_d;
  logic             busy_q, busy_d;

  // Winner selection and its request fields
  logic             win;
  logic [AW-1:0]    win_addr;
  logic [15:0]      win_dati;
  logic             win_we_hi;
  logic             win_we_lo;

  // On a tie the requester not granted last time wins; otherwise whichever
  // single requester is asking. Only consumed in IDLE with a request present.
  always_comb begin
    win = bus.r1_req;
    if (bus.r0_req && bus.r1_req) begin
      win = ~last_q;
    end
    win_addr  = win ? bus.r1_addr  : bus.r0_addr;
    win_dati  = win ? bus.r1_dati  : bus.r0_dati;
    win_we_hi = win ? bus.r1_we_hi : bus.r0_we_hi;
    win_we_lo = win ? bus.r1_we_lo : bus.r0_we_lo;
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_dati_d  = mem_dati_q;
    mem_oe_d    = mem_oe_q;
    mem_we_hi_d = mem_we_hi_q;
    mem_we_lo_d = mem_we_lo_q;
    r0_ack_d    = 1'b0;
    r1_ack_d    = 1'b0;
    r0_dato_d   = r0_dato_q;
    r1_dato_d   = r1_dato_q;

    unique case (state_q)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          mem_addr_d  = win_addr;
          mem_dati_d  = win_dati;
          mem_we_hi_d = win_we_hi;
          mem_we_lo_d = win_we_lo;
          mem_oe_d    = ~(win_we_hi | win_we_lo);
          gnt_d       = win;
          last_d      = win;
          cnt_d       = CNT_LOAD;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          // Last strobe cycle: mem_dato is sampled here so the requester
          // sees it together with its ack.
          if (mem_oe_q) begin
            if (gnt_q) begin
              r1_dato_d = bus.mem_dato;
            end else begin
              r0_dato_d = bus.mem_dato;
            end
          end
          mem_oe_d    = 1'b0;
          mem_we_hi_d = 1'b0;
          mem_we_lo_d = 1'b0;
          r0_ack_d    = ~gnt_q;
          r1_ack_d    = gnt_q;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops the strobes immediately
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      mem_addr_q  <= '0;
      mem_dati_q  <= '0;
      mem_oe_q    <= 1'b0;
      mem_we_hi_q <= 1'b0;
      mem_we_lo_q <= 1'b0;
      r0_ack_q    <= 1'b0;
      r1_ack_q    <= 1'b0;
      r0_dato_q   <= '0;
      r1_dato_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_dati_q  <= mem_dati_d;
      mem_oe_q    <= mem_oe_d;
      mem_we_hi_q <= mem_we_hi_d;
      mem_we_lo_q <= mem_we_lo_d;
      r0_ack_q    <= r0_ack_d;
      r1_ack_q    <= r1_ack_d;
      r0_dato_q   <= r0_dato_d;
      r1_dato_q   <= r1_dato_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_dati  = mem_dati_q;
  assign bus.mem_oe    = mem_oe_q;
  assign bus.mem_we_hi = mem_we_hi_q;
  assign bus.mem_we_lo = mem_we_lo_q;
  assign bus.r0_ack    = r0_ack_q;
  assign bus.r1_ack    = r1_ack_q;
  assign bus.r0_dato   = r0_dato_q;
  assign bus.r1_dato   = r1_dato_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;
  localparam int AW = 24;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic sys_rst;
  int   total = 0;
  int   bad   = 0;
  time  t_ack;
  time  tp;

  mem_arb_if #(.AW(AW)) b4 ();
  mem_arb_if #(.AW(AW)) b1 ();

  mem_arb #(.AW(AW), .WAIT_CYC(W)) dut4 (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (b4.slave)
  );

  mem_arb #(.AW(AW), .WAIT_CYC(1)) dut1 (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (b1.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b4.r0_req = 0; b4.r1_req = 0; b4.r0_addr = '0; b4.r1_addr = '0;
    b4.r0_dati = '0; b4.r1_dati = '0; b4.r0_we_hi = 0; b4.r0_we_lo = 0;
    b4.r1_we_hi = 0; b4.r1_we_lo = 0; b4.mem_dato = '0;
    b1.r0_req = 0; b1.r1_req = 0; b1.r0_addr = '0; b1.r1_addr = '0;
    b1.r0_dati = '0; b1.r1_dati = '0; b1.r0_we_hi = 0; b1.r0_we_lo = 0;
    b1.r1_we_hi = 0; b1.r1_we_lo = 0; b1.mem_dato = '0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_addr"},  b4.mem_addr, 0);
    chk({tag, "_dati"},  b4.mem_dati, 0);
    chk({tag, "_oe"},    b4.mem_oe, 0);
    chk({tag, "_wehi"},  b4.mem_we_hi, 0);
    chk({tag, "_welo"},  b4.mem_we_lo, 0);
    chk({tag, "_ack0"},  b4.r0_ack, 0);
    chk({tag, "_ack1"},  b4.r1_ack, 0);
    chk({tag, "_dato0"}, b4.r0_dato, 0);
    chk({tag, "_dato1"}, b4.r1_dato, 0);
    chk({tag, "_busy"},  b4.busy, 0);
  endtask

  // Next posedge is the grant edge. Checks the W strobe cycles and returns
  // positioned in the ack cycle, with t_ack recording its time.
  task automatic do_access(input string tag, input int who, input logic [AW-1:0] addr,
                           input logic oe, input logic hi, input logic lo,
                           input logic [15:0] dati);
    step();
    for (int i = 0; i < W; i++) begin
      chk($sformatf("%s_oe%0d", tag, i),   b4.mem_oe, oe);
      chk($sformatf("%s_hi%0d", tag, i),   b4.mem_we_hi, hi);
      chk($sformatf("%s_lo%0d", tag, i),   b4.mem_we_lo, lo);
      chk($sformatf("%s_addr%0d", tag, i), b4.mem_addr, addr);
      chk($sformatf("%s_dati%0d", tag, i), b4.mem_dati, dati);
      chk($sformatf("%s_busy%0d", tag, i), b4.busy, 1);
      chk($sformatf("%s_ackx%0d", tag, i), {b4.r1_ack, b4.r0_ack}, 0);
      if (i < W - 1) step();
    end
    step();
    t_ack = $time;
    chk({tag, "_ack0"},  b4.r0_ack, (who == 0));
    chk({tag, "_ack1"},  b4.r1_ack, (who == 1));
    chk({tag, "_strb"},  {b4.mem_oe, b4.mem_we_hi, b4.mem_we_lo}, 0);
    chk({tag, "_dbusy"}, b4.busy, 1);
  endtask

  initial begin
    idle_inputs();
    sys_rst = 1;
    repeat (3) step();
    chk_outs_zero("rst");
    chk("rst_b1busy", b1.busy, 0);
    sys_rst = 0;
    step();
    chk("idle_busy", b4.busy, 0);

    // Single read from requester 0
    b4.r0_req = 1; b4.r0_addr = 24'h000123; b4.mem_dato = 16'hBEEF;
    do_access("rd", 0, 24'h000123, 1, 0, 0, 16'h0000);
    chk("rd_dato", b4.r0_dato, 16'hBEEF);
    b4.r0_req = 0;
    step();
    chk("rd_idle_busy", b4.busy, 0);
    chk("rd_idle_ack", b4.r0_ack, 0);
    chk("rd_dato_hold", b4.r0_dato, 16'hBEEF);

    // Simultaneous requests after reset: 0,1,0,1
    sys_rst = 1;
    step();
    chk("rst2_dato0", b4.r0_dato, 0);
    b4.r0_req = 1; b4.r0_addr = 24'h000100;
    b4.r1_req = 1; b4.r1_addr = 24'h000200;
    b4.mem_dato = 16'h1111;
    sys_rst = 0;
    do_access("tie_a", 0, 24'h000100, 1, 0, 0, 16'h0000);
    tp = t_ack;
    chk("tie_a_dato", b4.r0_dato, 16'h1111);
    b4.mem_dato = 16'h2222;
    step();
    chk("tie_a_idle", b4.busy, 0);
    do_access("tie_b", 1, 24'h000200, 1, 0, 0, 16'h0000);
    chk("tie_b_period", 32'(t_ack - tp), 60);
    tp = t_ack;
    chk("tie_b_dato1", b4.r1_dato, 16'h2222);
    chk("tie_b_dato0", b4.r0_dato, 16'h1111);
    b4.mem_dato = 16'h3333;
    step();
    do_access("tie_c", 0, 24'h000100, 1, 0, 0, 16'h0000);
    chk("tie_c_period", 32'(t_ack - tp), 60);
    tp = t_ack;
    chk("tie_c_dato", b4.r0_dato, 16'h3333);
    b4.mem_dato = 16'h4444;
    step();
    do_access("tie_d", 1, 24'h000200, 1, 0, 0, 16'h0000);
    chk("tie_d_period", 32'(t_ack - tp), 60);
    chk("tie_d_dato", b4.r1_dato, 16'h4444);

    // Byte-lane write from requester 1
    b4.r0_req = 0;
    b4.r1_addr = 24'h000456; b4.r1_dati = 16'h12AB; b4.r1_we_lo = 1;
    b4.mem_dato = 16'hDEAD;
    step();
    chk("wr_idle", b4.busy, 0);
    do_access("wr", 1, 24'h000456, 0, 0, 1, 16'h12AB);
    chk("wr_dato1", b4.r1_dato, 16'h4444);
    chk("wr_dato0", b4.r0_dato, 16'h3333);
    b4.r1_req = 0; b4.r1_we_lo = 0;
    step();
    chk("wr_idle2", b4.busy, 0);

    // Back-to-back reads from requester 0 with new address each ack
    b4.r0_req = 1; b4.r0_addr = 24'h000010; b4.mem_dato = 16'hA000;
    for (int i = 0; i < 3; i++) begin
      do_access($sformatf("b2b%0d", i), 0, 24'h000010 + AW'(i), 1, 0, 0, 16'h0000);
      chk($sformatf("b2b%0d_dato", i), b4.r0_dato, 16'hA000 + 16'(i));
      if (i > 0) chk($sformatf("b2b%0d_period", i), 32'(t_ack - tp), 60);
      tp = t_ack;
      b4.r0_addr = 24'h000011 + AW'(i);
      b4.mem_dato = 16'hA001 + 16'(i);
      if (i == 2) b4.r0_req = 0;
      step();
      chk($sformatf("b2b%0d_idle", i), b4.busy, 0);
    end

    // Reset in the 2nd ACCESS cycle, then a fresh access
    b4.r0_req = 1; b4.r0_addr = 24'h000077; b4.mem_dato = 16'h5555;
    step();
    chk("mra_oe1", b4.mem_oe, 1);
    step();
    chk("mra_oe2", b4.mem_oe, 1);
    sys_rst = 1;
    #1;
    chk_outs_zero("mra");
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("mra_noack%0d", i), {b4.r1_ack, b4.r0_ack}, 0);
      chk($sformatf("mra_busy%0d", i), b4.busy, 0);
    end
    sys_rst = 0;
    do_access("mra_re", 0, 24'h000077, 1, 0, 0, 16'h0000);
    chk("mra_re_dato", b4.r0_dato, 16'h5555);
    b4.r0_req = 0;
    step();
    chk("mra_re_idle", b4.busy, 0);

    // WAIT_CYC=1: requester 1 drops req during its ACCESS cycle
    b1.r1_req = 1; b1.r1_addr = 24'h000005; b1.mem_dato = 16'h3C3C;
    step();
    chk("drop_oe", b1.mem_oe, 1);
    chk("drop_busy", b1.busy, 1);
    chk("drop_addr", b1.mem_addr, 24'h000005);
    chk("drop_noack", b1.r1_ack, 0);
    b1.r1_req = 0;
    step();
    chk("drop_ack1", b1.r1_ack, 1);
    chk("drop_ack0", b1.r0_ack, 0);
    chk("drop_dato", b1.r1_dato, 16'h3C3C);
    chk("drop_oe_off", b1.mem_oe, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("drop_after_ack%0d", i), b1.r1_ack, 0);
      chk($sformatf("drop_after_busy%0d", i), b1.busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
